// File: rtl/ham_weight_unit.sv
// Multi-cycle population count: BITS_PER_CYCLE bits per COUNT cycle, result held on ham_out.
// Optional macro HAM_EARLY_EXIT_EN ends counting once no set bits remain in the shift register.
module ham_weight_unit #(
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] operand,
    output logic        busy,
    output logic        done,
    output logic [31:0] ham_out
);

    localparam int N     = 32 / BITS_PER_CYCLE;
    localparam int PW    = $clog2(BITS_PER_CYCLE + 1);
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        sr_q, sr_d;
    logic [5:0]         acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         ham_q, ham_d;

    logic [PW-1:0]      part;
    logic [5:0]         sum;
    logic [31:0]        sr_shift;
    logic               last;
    logic               accept;

    // Partial popcount of the low chunk, zero-extended into the 6-bit accumulator.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        part = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            part = part + PW'(sr_q[i]);
        end
        sum      = acc_q + 6'(part);
        sr_shift = sr_q >> BITS_PER_CYCLE;
`ifdef HAM_EARLY_EXIT_EN
        last     = (cnt_q == CNT_W'(N - 1)) || (sr_shift == 32'd0);
`else
        last     = (cnt_q == CNT_W'(N - 1));
`endif
        accept   = (state_q != COUNT) && start;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = COUNT;
            COUNT:   if (last)  state_d = DONE;
            DONE:    state_d = start ? COUNT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        sr_d  = sr_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        ham_d = ham_q;
        if (accept) begin
            sr_d  = operand;
            acc_d = '0;
            cnt_d = '0;
        end else if (state_q == COUNT) begin
            sr_d  = sr_shift;
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
                ham_d = sum;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ham_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ham_q   <= ham_d;
        end
    end

    // Outputs are pure state decodes; start has no combinational path to them.
    always_comb begin
        busy    = (state_q == COUNT);
        done    = (state_q == DONE);
        ham_out = {26'b0, ham_q};
    end

endmodule

// File: doc/ham_weight_unit.md
# ham_weight_unit

Multi-cycle Hamming-weight (population count) unit that produces the value driven onto the ALU result multiplexer's `HAM_out` input. It accepts a 32-bit operand on a start pulse and counts its set bits `BITS_PER_CYCLE` bits at a time. It then holds the zero-extended count on `ham_out` until the next accepted operand. The control unit stalls on `busy` and advances on the `done` pulse.

## Interface
- `BITS_PER_CYCLE`, default 4, bits consumed per counting cycle.
  - Legal values: 1, 2, 4, 8.
  - Defines `N = 32 / BITS_PER_CYCLE` counting cycles.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request to count `operand`; sampled only when the unit is accepting (see Operation).
- `operand` input 32: value to count; captured on the accepting edge only.
- `busy` output 1: high while counting.
- `done` output 1: one-cycle pulse, high in the cycle `ham_out` first shows the new result.
- `ham_out` output 32: result, `{26'b0, count[5:0]}`; holds its value between operations.

## Operation
- States: IDLE, COUNT, DONE.
- Accepting states are IDLE and DONE.
  - An edge with `start=1` in an accepting state loads `operand` into shift register `sr`, clears a 6-bit accumulator `acc` and a cycle counter `cnt`, and moves to COUNT.
  - `start=1` while in COUNT is ignored; it is neither queued nor does it abort the current operation.
- In each COUNT cycle:
  - `acc <= acc + popcount(sr[BITS_PER_CYCLE-1:0])`.
  - `sr <= sr >> BITS_PER_CYCLE`.
  - `cnt <= cnt + 1`.
- Termination: the COUNT cycle with `cnt == N-1` is the last one.
  - On that edge `ham_out` is loaded with the final sum (acc plus this cycle's partial count), and the state moves to DONE.
- DONE lasts exactly one cycle, then returns to IDLE unless `start=1` is accepted in that cycle.
- Width rules:
  - `acc` is 6 bits; the maximum value is 32, so it never overflows.
  - The partial popcount is `clog2(BITS_PER_CYCLE+1)` bits, zero-extended before the add.
- Outputs:
  - `busy = (state == COUNT)`.
  - `done = (state == DONE)`.
  - Both are registered-state decodes, with no combinational path from `start`.
- Reset values: state IDLE; `busy=0`; `done=0`; `ham_out=0`; `sr=0`; `acc=0`; `cnt=0`.
- Reset mid-operation: the operation is abandoned, no `done` pulse is issued, and `ham_out` returns to 0.
- `rst` and `start` asserted in the same cycle: `rst` wins and the start is lost.

## Timing
- Label the accepting edge as cycle 0.
- COUNT occupies cycles 1..N, with `busy=1` throughout.
- `done=1` and the new `ham_out` appear in cycle N+1. With default N=8 that is cycle 9.
- Back-to-back operation: `start` in the DONE cycle is accepted, and `busy` rises in the next cycle. Sustained throughput is one result per N+1 cycles.
- `ham_out` changes only on the terminating COUNT edge or on reset. It stays stable through IDLE, through the whole next COUNT phase, and through ignored starts.
- `operand` may change freely after cycle 0.

## Configuration
- Macro: `HAM_EARLY_EXIT_EN`.
- Defined: COUNT also terminates when the shifted register becomes zero, i.e. on the edge where `(sr >> BITS_PER_CYCLE) == 0`, whichever of this and `cnt == N-1` comes first.
  - Operand 0 or 1 terminates after one COUNT cycle, with `done` in cycle 2.
  - Latency equals 1 + the number of BITS_PER_CYCLE-sized chunks up to and including the highest set bit (minimum one COUNT cycle).
- Undefined: latency is fixed at N COUNT cycles, and the `sr == 0` comparator is not built.
- Results are identical either way; only latency differs.

## Test plan
All scenarios use the default `BITS_PER_CYCLE=4`.
- Full operand: `operand=0xFFFFFFFF`, `start` in cycle 0 -> `busy` high in cycles 1–8, `done` pulse in cycle 9, `ham_out=0x00000020`, held after `done`.
- Zero operand: `operand=0x00000000` -> `ham_out=0`. `done` in cycle 9 without the macro; with `HAM_EARLY_EXIT_EN`, `done` in cycle 2.
- Top bit only: `operand=0x80000000` -> `ham_out=1`, `done` in cycle 9 with or without the macro. `operand=0x0000000F` with the macro -> `ham_out=4`, `done` in cycle 2.
- Ignored start: `start` with `operand=0xA5A5A5A5`, then `start` with `0xFFFFFFFF` in cycle 4 -> the second start is ignored, and the unit returns `ham_out=16` in cycle 9.
- Back-to-back: `start` with `0x0000FFFF` held high from cycle 0 -> `done` with `ham_out=16` in cycle 9, which also re-accepts the (unchanged) operand. A second `done` with `ham_out=16` appears in cycle 18; no idle cycle between operations.
- Reset mid-operation: `rst=1` in cycle 5 of a `0x12345678` operation -> next cycle `busy=0`, `done=0`, `ham_out=0`, and no `done` pulse follows. A fresh start then yields `ham_out=13` after the normal latency.
